// File: rtl/registros_banco_param_pkg.sv
// Shared types and default sizing for the parametrised register bank.
// Latency: n/a (types only); backpressure: n/a.
package registros_pkg;

  typedef enum logic [1:0] {
    WR_ALU  = 2'b00,
    WR_PC   = 2'b01,
    WR_IMM  = 2'b10,
    WR_RSVD = 2'b11
  } wr_sel_t;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_WAIT = 1'b1
  } ld_state_t;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_NUM_REGS     = 8;
  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_ZERO_R0      = 1;
  localparam int DEF_LOAD_TIMEOUT = 15;

  // Timeout counter only has to reach LOAD_TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/registros_banco_param_if.sv
// Operand, write-port and load-return signal bundle between decode/memory and the register bank.
// Latency: wires only; backpressure is carried back on o_Stall.
interface registros_banco_param_if
  import registros_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0]   i_Rd_A_Addr;
  logic [ADDR_W-1:0]   i_Rd_B_Addr;
  logic [DATA_W-1:0]   o_Operando_A;
  logic [DATA_W-1:0]   o_Operando_B;
  logic [2*DATA_W-1:0] o_Operandos;
  logic [2*DATA_W-1:0] o_Direccion_Dato;
  logic [DATA_W-1:0]   o_Direccion_Salto;

  logic                i_Wr_En;
  logic [ADDR_W-1:0]   i_Wr_Addr;
  logic [1:0]          i_Wr_Sel;
  logic [DATA_W-1:0]   i_Resultado_ALU;
  logic [DATA_W-1:0]   i_Direccion_PC;
  logic [DATA_W-1:0]   i_Inmediato;

  logic                i_Load_Req;
  logic [ADDR_W-1:0]   i_Load_Addr;
  logic                i_Datos_Valid;
  logic [DATA_W-1:0]   i_Datos_Entrada;
  logic                o_Load_Busy;
  logic                o_Stall;
  logic                o_Load_Err;

  modport slave (
    input  i_Rd_A_Addr, i_Rd_B_Addr,
    input  i_Wr_En, i_Wr_Addr, i_Wr_Sel, i_Resultado_ALU, i_Direccion_PC, i_Inmediato,
    input  i_Load_Req, i_Load_Addr, i_Datos_Valid, i_Datos_Entrada,
    output o_Operando_A, o_Operando_B, o_Operandos, o_Direccion_Dato, o_Direccion_Salto,
    output o_Load_Busy, o_Stall, o_Load_Err
  );

  modport master (
    output i_Rd_A_Addr, i_Rd_B_Addr,
    output i_Wr_En, i_Wr_Addr, i_Wr_Sel, i_Resultado_ALU, i_Direccion_PC, i_Inmediato,
    output i_Load_Req, i_Load_Addr, i_Datos_Valid, i_Datos_Entrada,
    input  o_Operando_A, o_Operando_B, o_Operandos, o_Direccion_Dato, o_Direccion_Salto,
    input  o_Load_Busy, o_Stall, o_Load_Err
  );

endinterface

// File: rtl/registros_scoreboard.sv
// Single-outstanding-load tracker: dest latch, timeout counter, sticky error, hazard stall (REGISTROS_BYPASS_EN relaxes read stall).
// Latency: load commit is combinational on the data-valid cycle; stall is combinational and drops stalled requests.
module registros_scoreboard
  import registros_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              datos_valid,
  output logic              load_busy,
  output logic              stall,
  output logic              load_err,
  output logic [ADDR_W-1:0] dest,
  output logic              ld_commit
);

  localparam int                CNT_W   = cnt_width(LOAD_TIMEOUT);
  localparam bit                TO_EN   = (LOAD_TIMEOUT != 0);
  localparam logic [CNT_W-1:0]  TO_LAST = TO_EN ? CNT_W'(LOAD_TIMEOUT - 1) : '0;

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] dest_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_nxt;
  logic              rd_hit;
  logic              rd_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_IDLE;
      dest     <= '0;
      cnt      <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      dest     <= dest_nxt;
      cnt      <= cnt_nxt;
      load_err <= err_nxt;
    end
  end

  always_comb begin
    rd_hit = (rd_a_addr == dest) || (rd_b_addr == dest);
`ifdef REGISTROS_BYPASS_EN
    // Returning data is forwarded to the read ports, so the read need not wait.
    rd_stall = rd_hit && !datos_valid;
`else
    rd_stall = rd_hit;
`endif
    stall = (state == LD_WAIT) &&
            (rd_stall ||
             (wr_en && (wr_addr == dest)) ||
             (load_req && !datos_valid));
  end

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    cnt_nxt   = cnt;
    err_nxt   = load_err;
    ld_commit = 1'b0;
    case (state)
      LD_IDLE: begin
        // Data with nothing outstanding is late or spurious: flag it, never write.
        if (datos_valid) err_nxt = 1'b1;
        if (load_req) begin
          state_nxt = LD_WAIT;
          dest_nxt  = load_addr;
          cnt_nxt   = '0;
        end
      end
      LD_WAIT: begin
        if (datos_valid) begin
          ld_commit = 1'b1;
          if (load_req && !stall) begin
            dest_nxt = load_addr;
            cnt_nxt  = '0;
          end else begin
            state_nxt = LD_IDLE;
          end
        end else if (TO_EN && (cnt == TO_LAST)) begin
          state_nxt = LD_IDLE;
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else if (TO_EN) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase
  end

  assign load_busy = (state == LD_WAIT);

endmodule

// File: rtl/registros_banco_param.sv
// NUM_REGS x DATA_W register bank, two async read ports, muxed write port, one outstanding load; REGISTROS_BYPASS_EN forwards committing writes.
// Latency: reads combinational, writes visible next cycle (same cycle with bypass); o_Stall drops the request.
module registros_banco_param
  import registros_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int ZERO_R0      = DEF_ZERO_R0,
  parameter int LOAD_TIMEOUT = DEF_LOAD_TIMEOUT
) (
  input logic                    i_Clk,
  input logic                    i_Rst,
  registros_banco_param_if.slave bus
);

  localparam bit R0_HARD = (ZERO_R0 != 0);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wr_data;
  wr_sel_t           wr_sel;
  logic              wr_commit;
  logic              ld_commit;
  logic              ld_write;
  logic [ADDR_W-1:0] dest;
  logic              stall;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  registros_scoreboard #(
    .ADDR_W       (ADDR_W),
    .LOAD_TIMEOUT (LOAD_TIMEOUT)
  ) u_sb (
    .clk         (i_Clk),
    .rst         (i_Rst),
    .rd_a_addr   (bus.i_Rd_A_Addr),
    .rd_b_addr   (bus.i_Rd_B_Addr),
    .wr_en       (bus.i_Wr_En),
    .wr_addr     (bus.i_Wr_Addr),
    .load_req    (bus.i_Load_Req),
    .load_addr   (bus.i_Load_Addr),
    .datos_valid (bus.i_Datos_Valid),
    .load_busy   (bus.o_Load_Busy),
    .stall       (stall),
    .load_err    (bus.o_Load_Err),
    .dest        (dest),
    .ld_commit   (ld_commit)
  );

  assign wr_sel = wr_sel_t'(bus.i_Wr_Sel);

  always_comb begin
    wr_data = '0;
    case (wr_sel)
      WR_ALU:  wr_data = bus.i_Resultado_ALU;
      WR_PC:   wr_data = bus.i_Direccion_PC;
      WR_IMM:  wr_data = bus.i_Inmediato;
      default: wr_data = '0;
    endcase
  end

  // R0 suppression is folded into both commit strobes so bypass never forwards to R0.
  assign wr_commit = bus.i_Wr_En && !stall && (wr_sel != WR_RSVD) &&
                     !(R0_HARD && (bus.i_Wr_Addr == '0));
  assign ld_write  = ld_commit && !(R0_HARD && (dest == '0));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_commit) regs[bus.i_Wr_Addr] <= wr_data;
      if (ld_write)  regs[dest]          <= bus.i_Datos_Entrada;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    val = regs[idx];
`ifdef REGISTROS_BYPASS_EN
    // Load return wins over a port write when both could forward.
    if (ld_write && (idx == dest))
      val = bus.i_Datos_Entrada;
    else if (wr_commit && (idx == bus.i_Wr_Addr))
      val = wr_data;
`endif
    if (R0_HARD && (idx == '0)) val = '0;
    return val;
  endfunction

  always_comb begin
    op_a = read_port(bus.i_Rd_A_Addr);
    op_b = read_port(bus.i_Rd_B_Addr);
  end

  assign bus.o_Operando_A      = op_a;
  assign bus.o_Operando_B      = op_b;
  assign bus.o_Operandos       = {op_a, op_b};
  assign bus.o_Direccion_Dato  = {op_a, op_b};
  assign bus.o_Direccion_Salto = op_a;
  assign bus.o_Stall           = stall;

endmodule

// File: tb/tb_registros_banco_param.sv
// Directed bench for registros_banco_param: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_registros_banco_param;
  import registros_pkg::*;

  localparam int K_OPA   = 0;
  localparam int K_OPS   = 1;
  localparam int K_SALTO = 2;
  localparam int K_DIRD  = 3;
  localparam int K_BUSY  = 4;
  localparam int K_STALL = 5;
  localparam int K_ERR   = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t e;

  registros_banco_param_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  registros_banco_param #(
    .DATA_W(8), .NUM_REGS(8), .ADDR_W(3), .ZERO_R0(1), .LOAD_TIMEOUT(15)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_OPA:   return {24'h0, bus.o_Operando_A};
      K_OPS:   return {16'h0, bus.o_Operandos};
      K_SALTO: return {24'h0, bus.o_Direccion_Salto};
      K_DIRD:  return {16'h0, bus.o_Direccion_Dato};
      K_BUSY:  return {31'h0, bus.o_Load_Busy};
      K_STALL: return {31'h0, bus.o_Stall};
      K_ERR:   return {31'h0, bus.o_Load_Err};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
      end else if (obs(e.kind) !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", e.name, cyc, obs(e.kind), e.val);
      end
    end
  end

  task automatic chk(input int kind, input logic [31:0] val, input string name);
    exp_t x;
    x.cyc = cyc; x.kind = kind; x.val = val; x.name = name;
    sb_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_Rd_A_Addr = '0;     bus.i_Rd_B_Addr = '0;
    bus.i_Wr_En = 1'b0;       bus.i_Wr_Addr = '0;     bus.i_Wr_Sel = 2'b00;
    bus.i_Resultado_ALU = '0; bus.i_Direccion_PC = '0; bus.i_Inmediato = '0;
    bus.i_Load_Req = 1'b0;    bus.i_Load_Addr = '0;
    bus.i_Datos_Valid = 1'b0; bus.i_Datos_Entrada = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [1:0] sel, input logic [7:0] d);
    idle();
    bus.i_Wr_En = 1'b1; bus.i_Wr_Addr = a; bus.i_Wr_Sel = sel;
    bus.i_Resultado_ALU = d; bus.i_Direccion_PC = d; bus.i_Inmediato = d;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    idle();
    bus.i_Rd_A_Addr = a; bus.i_Rd_B_Addr = b;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    rd(3, 5);
    chk(K_OPS, 32'h0000, "reset_ops"); chk(K_BUSY, 0, "reset_busy");
    chk(K_ERR, 0, "reset_err");        chk(K_STALL, 0, "reset_stall");
    tick();

    // ALU and PC writes, read back
    wr(3, 2'b00, 8'hAA); tick();
    wr(5, 2'b01, 8'h55); tick();
    rd(3, 5);
    chk(K_OPS, 32'hAA55, "ops_a3_b5"); chk(K_SALTO, 32'hAA, "salto_a3");
    chk(K_DIRD, 32'hAA55, "dir_dato");
    tick();

    // R0 hard-wired, reserved select dropped
    wr(0, 2'b10, 8'hFF); tick();
    wr(2, 2'b00, 8'h21); tick();
    wr(2, 2'b11, 8'h12); tick();
    rd(0, 2);
    chk(K_OPS, 32'h0021, "r0_zero_r2_kept");
    tick();

    // Load to R4, read hazard, stalled write to R7 dropped, return on third WAIT cycle
    idle(); bus.i_Load_Req = 1'b1; bus.i_Load_Addr = 3'd4;
    chk(K_STALL, 0, "idle_no_stall");
    tick();
    rd(4, 0); bus.i_Wr_En = 1'b1; bus.i_Wr_Addr = 3'd7; bus.i_Resultado_ALU = 8'h99;
    chk(K_STALL, 1, "wait_rd_hazard"); chk(K_BUSY, 1, "wait_busy");
    tick();
    rd(0, 0);
    chk(K_STALL, 0, "wait_no_hazard");
    tick();
    rd(0, 0); bus.i_Datos_Valid = 1'b1; bus.i_Datos_Entrada = 8'h3C;
    tick();
    rd(4, 7);
    chk(K_OPS, 32'h3C00, "load_r4_r7_dropped"); chk(K_BUSY, 0, "load_done_busy");
    chk(K_STALL, 0, "load_done_stall");
    tick();

    // Timeout on R6
    wr(6, 2'b00, 8'h66); tick();
    idle(); bus.i_Load_Req = 1'b1; bus.i_Load_Addr = 3'd6;
    tick();
    idle();
    for (int i = 0; i < 14; i++) tick();
    chk(K_BUSY, 1, "last_wait_cycle"); chk(K_ERR, 0, "no_err_yet");
    tick();
    rd(6, 0);
    chk(K_BUSY, 0, "timeout_idle"); chk(K_ERR, 1, "timeout_err");
    chk(K_OPA, 32'h66, "timeout_r6_kept");
    tick();
    idle(); bus.i_Datos_Valid = 1'b1; bus.i_Datos_Entrada = 8'hEE;
    tick();
    rd(6, 0);
    chk(K_OPA, 32'h66, "late_data_no_write"); chk(K_ERR, 1, "late_data_err");
    tick();

    // Load return to R1 with back-to-back load to R2
    idle(); bus.i_Load_Req = 1'b1; bus.i_Load_Addr = 3'd1;
    tick();
    idle(); bus.i_Datos_Valid = 1'b1; bus.i_Datos_Entrada = 8'h11;
    bus.i_Load_Req = 1'b1; bus.i_Load_Addr = 3'd2;
    chk(K_STALL, 0, "chain_no_stall");
    tick();
    rd(1, 3);
    chk(K_OPS, 32'h11AA, "chain_r1_written"); chk(K_BUSY, 1, "chain_busy");
    chk(K_STALL, 0, "chain_rd_other");
    tick();
    rd(0, 2);
    chk(K_STALL, 1, "chain_dest_r2");
    tick();

    // Reset mid-WAIT
    rst = 1'b1; idle(); tick();
    rst = 1'b0;
    rd(3, 2);
    chk(K_OPS, 32'h0000, "midreset_regs"); chk(K_BUSY, 0, "midreset_busy");
    chk(K_ERR, 0, "midreset_err");         chk(K_STALL, 0, "midreset_stall");
    tick();

    // Same-cycle visibility of a port write and a load return
    wr(7, 2'b00, 8'h77); bus.i_Rd_A_Addr = 3'd7;
`ifdef REGISTROS_BYPASS_EN
    chk(K_OPA, 32'h77, "bypass_wr_same");
`else
    chk(K_OPA, 32'h00, "nobypass_wr_same");
`endif
    tick();
    rd(7, 0);
    chk(K_OPA, 32'h77, "wr_next_cycle");
    tick();
    idle(); bus.i_Load_Req = 1'b1; bus.i_Load_Addr = 3'd5;
    tick();
    rd(5, 0); bus.i_Datos_Valid = 1'b1; bus.i_Datos_Entrada = 8'h5A;
`ifdef REGISTROS_BYPASS_EN
    chk(K_STALL, 0, "bypass_ld_nostall"); chk(K_OPA, 32'h5A, "bypass_ld_same");
`else
    chk(K_STALL, 1, "nobypass_ld_stall"); chk(K_OPA, 32'h00, "nobypass_ld_same");
`endif
    tick();
    rd(5, 0);
    chk(K_OPA, 32'h5A, "ld_next_cycle"); chk(K_BUSY, 0, "ld_next_busy");
    tick();

    idle();
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registros_banco_param.md
Name: registros_banco_param

Overview:
- Parametrised successor to the fixed 8-bit register bank of the teaching micro.
- Provides NUM_REGS x DATA_W registers with two asynchronous read ports and one write port. The write source is selectable: ALU result, PC, immediate or load data.
- Supports one outstanding memory load, tracked by a scoreboard FSM with timeout.
- Sits between decode/ALU and the data-memory interface; raises o_Stall on hazards.

Parameters:
DATA_W, 8, register/operand width
NUM_REGS, 8, number of registers (power of two, >=2)
ADDR_W, 3, register index width; must equal log2(NUM_REGS)
ZERO_R0, 1, 1 = R0 reads 0 and ignores writes
LOAD_TIMEOUT, 15, cycles to wait for load data before abort; 0 = never abort

Ports:
i_Clk  in  1  clock, rising edge
i_Rst  in  1  synchronous reset, active-high
i_Rd_A_Addr  in  ADDR_W  read port A index
i_Rd_B_Addr  in  ADDR_W  read port B index
o_Operando_A  out  DATA_W  register[A]
o_Operando_B  out  DATA_W  register[B]
o_Operandos  out  2*DATA_W  {o_Operando_A, o_Operando_B} to ALU
o_Direccion_Dato  out  2*DATA_W  {o_Operando_A, o_Operando_B} as memory address pair
o_Direccion_Salto  out  DATA_W  o_Operando_A, jump target
i_Wr_En  in  1  write request
i_Wr_Addr  in  ADDR_W  write index
i_Wr_Sel  in  2  00 ALU, 01 PC, 10 immediate, 11 reserved (write dropped)
i_Resultado_ALU  in  DATA_W  ALU result
i_Direccion_PC  in  DATA_W  PC value (link)
i_Inmediato  in  DATA_W  immediate
i_Load_Req  in  1  start load into i_Load_Addr
i_Load_Addr  in  ADDR_W  load destination
i_Datos_Valid  in  1  load data present
i_Datos_Entrada  in  DATA_W  load data
o_Load_Busy  out  1  load outstanding
o_Stall  out  1  hazard, upstream must hold
o_Load_Err  out  1  sticky: timeout or unexpected data

Behaviour:
- Reset: all registers 0, FSM IDLE, timeout counter 0, o_Load_Busy=0, o_Load_Err=0. o_Stall is then combinational from inputs with the scoreboard clear.
- Reads are combinational from the array. If ZERO_R0, index 0 reads 0.
- Write: on an edge with i_Wr_En=1, o_Stall=0 and i_Wr_Sel!=11, the selected source is written to i_Wr_Addr. Writes to R0 are dropped if ZERO_R0.
- Scoreboard FSM states: IDLE, WAIT.
  - IDLE: i_Load_Req=1 and o_Stall=0 -> latch dest, go to WAIT, clear counter.
  - WAIT: i_Datos_Valid=1 -> write i_Datos_Entrada to dest, go to IDLE. If i_Load_Req=1 in the same cycle, accept it and stay in WAIT with the new dest.
  - WAIT: counter reaches LOAD_TIMEOUT-1 without valid -> go to IDLE, set o_Load_Err, dest not written.
- o_Load_Busy = (state==WAIT).
- o_Stall = 1 when state==WAIT and any of the following hold:
  - Rd A or Rd B index equals dest;
  - i_Wr_En with i_Wr_Addr==dest;
  - i_Load_Req without i_Datos_Valid.
- In IDLE, o_Stall=0.
- A stalled write or load request is dropped, not queued.
- i_Datos_Valid in IDLE is ignored (no write) and sets o_Load_Err. This covers late data after reset or timeout.
- Load return and a port write in the same cycle to different indices: both commit. Same index cannot occur, because the port write stalls.
- Load to R0 with ZERO_R0: the FSM runs normally, the write is suppressed.
- Reset mid-load: the FSM returns to IDLE and the pending data is discarded.
- o_Load_Err clears only on reset.

Optional Feature:
REGISTROS_BYPASS_EN.
- Defined: a read port whose index matches a write committing this cycle returns the write data combinationally. This applies to both port writes and load returns; the load return takes priority over a port write for forwarding. Also when defined, a read of dest in WAIT with i_Datos_Valid=1 is not stalled.
- Undefined: reads return the stored array value only. New data is visible the cycle after the edge.

Decomposition:
- Package registros_pkg holds:
  - wr_sel_t enum: WR_ALU, WR_PC, WR_IMM, WR_RSVD;
  - ld_state_t enum: LD_IDLE, LD_WAIT;
  - default-width constants.
- Sub-module registros_scoreboard holds the FSM, dest latch, timeout counter, error flag and stall terms. The top holds the array, write mux, read/bypass logic and output concatenations.

Test Plan:
- Reset, then write ALU=0xAA to R3 and PC=0x55 to R5; read A=3, B=5 next cycle -> o_Operandos=0xAA55, o_Direccion_Salto=0xAA.
- ZERO_R0=1: write immediate 0xFF to R0 -> R0 reads 0x00; i_Wr_Sel=11 to R2 -> R2 unchanged.
- Load to R4, read A=4 during WAIT -> o_Stall=1. Return 0x3C after 3 cycles -> R4=0x3C, o_Load_Busy=0, o_Stall=0 the next cycle.
- Load to R6, no valid for 15 cycles -> FSM IDLE, o_Load_Err=1, R6 unchanged. Later i_Datos_Valid -> no write, error stays 1.
- Load return to R1 plus new load to R2 in the same cycle -> R1 written, o_Load_Busy stays 1, dest=R2. Then reset mid-WAIT -> all registers 0, busy 0.
- Bypass (macro defined): write ALU=0x77 to R7 while reading A=7 -> o_Operando_A=0x77 the same cycle. Without the macro -> old value that cycle, 0x77 the next.
